// File: rtl/proc_ctrl_seq.sv
// Control sequencer for the 16-bit processor datapath: fetches a 9-bit instruction and walks T0-T3.
// Optional mvnz instruction (opcode 100) enabled by defining CTRL_EXT_OPS_EN.
module proc_ctrl_seq #(
  parameter int unsigned DATA_W = 32'd16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  input  logic              GNZ,
  output logic [7:0]        Rout,
  output logic              Gout,
  output logic              DINout,
  output logic [7:0]        Rin,
  output logic              Ain,
  output logic              Gin,
  output logic              AddSub,
  output logic              IRin,
  output logic              Done
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] ir_q, ir_d;

  logic [7:0] rout_s, rin_s;
  logic       gout_s, dinout_s, ain_s, gin_s, addsub_s, irin_s, done_s;
  logic [7:0] x_onehot_s, y_onehot_s;

  assign x_onehot_s = 8'd1 << ir_q[5:3];
  assign y_onehot_s = 8'd1 << ir_q[2:0];

  // State and instruction registers; reset abandons any partial instruction.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= T0;
      ir_q    <= 9'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state and bus control decode.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    rout_s   = 8'd0;
    rin_s    = 8'd0;
    gout_s   = 1'b0;
    dinout_s = 1'b0;
    ain_s    = 1'b0;
    gin_s    = 1'b0;
    addsub_s = 1'b0;
    irin_s   = 1'b0;
    done_s   = 1'b0;
    case (state_q)
      T0: begin
        irin_s = Run;
        if (Run) begin
          ir_d    = DIN[8:0];
          state_d = T1;
        end else begin
          state_d = T0;
        end
      end
      T1: begin
        case (ir_q[8:6])
          3'b000: begin
            rout_s  = y_onehot_s;
            rin_s   = x_onehot_s;
            done_s  = 1'b1;
            state_d = T0;
          end
          3'b001: begin
            dinout_s = 1'b1;
            rin_s    = x_onehot_s;
            done_s   = 1'b1;
            state_d  = T0;
          end
          3'b010, 3'b011: begin
            rout_s  = x_onehot_s;
            ain_s   = 1'b1;
            state_d = T2;
          end
`ifdef CTRL_EXT_OPS_EN
          3'b100: begin
            rout_s = y_onehot_s;
            done_s = 1'b1;
            if (GNZ) begin
              rin_s = x_onehot_s;
            end else begin
              rin_s = 8'd0;
            end
            state_d = T0;
          end
`endif
          default: begin
            // Illegal opcodes complete without touching any register.
            done_s  = 1'b1;
            state_d = T0;
          end
        endcase
      end
      T2: begin
        rout_s   = y_onehot_s;
        gin_s    = 1'b1;
        addsub_s = ir_q[6];
        state_d  = T3;
      end
      T3: begin
        gout_s  = 1'b1;
        rin_s   = x_onehot_s;
        done_s  = 1'b1;
        state_d = T0;
      end
      default: begin
        state_d = T0;
      end
    endcase
  end

  // Outputs are forced quiet for the whole time reset is held, even though Run may be high.
  assign Rout   = rout_s & {8{Resetn}};
  assign Rin    = rin_s & {8{Resetn}};
  assign Gout   = gout_s & Resetn;
  assign DINout = dinout_s & Resetn;
  assign Ain    = ain_s & Resetn;
  assign Gin    = gin_s & Resetn;
  assign AddSub = addsub_s & Resetn;
  assign IRin   = irin_s & Resetn;
  assign Done   = done_s & Resetn;

`ifdef CTRL_EXT_OPS_EN
  logic unused_s;
  assign unused_s = ^DIN[DATA_W-1:9];
`else
  logic unused_s;
  assign unused_s = ^{DIN[DATA_W-1:9], GNZ};
`endif

endmodule
